// File: rtl/cu_pkg.sv
// Shared opcode encodings, ALU function codes and the decoded control bundle
// for the decode-stage control unit.
package cu_pkg;

    localparam int unsigned OPW  = 9;
    localparam int unsigned ALUW = 4;

    localparam logic [OPW-1:0] NOP_OP  = 9'h000;
    localparam logic [OPW-1:0] SETC_OP = 9'h001;
    localparam logic [OPW-1:0] CLRC_OP = 9'h002;
    localparam logic [OPW-1:0] NOT_OP  = 9'h020;
    localparam logic [OPW-1:0] INC_OP  = 9'h021;
    localparam logic [OPW-1:0] DEC_OP  = 9'h022;
    localparam logic [OPW-1:0] OUT_OP  = 9'h023;
    localparam logic [OPW-1:0] IN_OP   = 9'h024;
    localparam logic [OPW-1:0] MOV_OP  = 9'h040;
    localparam logic [OPW-1:0] ADD_OP  = 9'h041;
    localparam logic [OPW-1:0] SUB_OP  = 9'h042;
    localparam logic [OPW-1:0] AND_OP  = 9'h043;
    localparam logic [OPW-1:0] OR_OP   = 9'h044;
    localparam logic [OPW-1:0] SHL_OP  = 9'h045;
    localparam logic [OPW-1:0] SHR_OP  = 9'h046;
    localparam logic [OPW-1:0] PUSH_OP = 9'h060;
    localparam logic [OPW-1:0] POP_OP  = 9'h061;
    localparam logic [OPW-1:0] LDM_OP  = 9'h062;
    localparam logic [OPW-1:0] LDD_OP  = 9'h063;
    localparam logic [OPW-1:0] STD_OP  = 9'h064;
    localparam logic [OPW-1:0] JZ_OP   = 9'h080;
    localparam logic [OPW-1:0] JN_OP   = 9'h081;
    localparam logic [OPW-1:0] JC_OP   = 9'h082;
    localparam logic [OPW-1:0] JMP_OP  = 9'h084;
    localparam logic [OPW-1:0] CALL_OP = 9'h086;
    localparam logic [OPW-1:0] RET_OP  = 9'h088;

    localparam logic [ALUW-1:0] ALU_NOP   = 4'b0000;
    localparam logic [ALUW-1:0] ALU_SETC  = 4'b0001;
    localparam logic [ALUW-1:0] ALU_CLRC  = 4'b0010;
    localparam logic [ALUW-1:0] ALU_PASS  = 4'b0011;
    localparam logic [ALUW-1:0] ALU_PASSB = 4'b0100;
    localparam logic [ALUW-1:0] ALU_NOT   = 4'b0101;
    localparam logic [ALUW-1:0] ALU_INC   = 4'b0110;
    localparam logic [ALUW-1:0] ALU_DEC   = 4'b0111;
    localparam logic [ALUW-1:0] ALU_ADD   = 4'b1000;
    localparam logic [ALUW-1:0] ALU_SUB   = 4'b1001;
    localparam logic [ALUW-1:0] ALU_AND   = 4'b1010;
    localparam logic [ALUW-1:0] ALU_OR    = 4'b1011;
    localparam logic [ALUW-1:0] ALU_SHL   = 4'b1100;
    localparam logic [ALUW-1:0] ALU_SHR   = 4'b1101;

    typedef struct packed {
        logic            branch;
        logic            data_read;
        logic            data_write;
        logic            dmr;
        logic            dmw;
        logic            ioe;
        logic            ior;
        logic            iow;
        logic            stack_op;
        logic            push_pop;
        logic            pass_imm;
        logic [ALUW-1:0] alu;
    } ctrl_t;

endpackage

// File: rtl/control_unit.sv
// Decode-stage control unit: combinational opcode-to-strobe decode feeding ID/EX,
// plus a sticky registered flag recording any undefined opcode seen.
module control_unit
    import cu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    output logic            branch,
    output logic            data_read,
    output logic            data_write,
    output logic            DMR,
    output logic            DMW,
    output logic            IOE,
    output logic            IOR,
    output logic            IOW,
    output logic            stack_operation,
    output logic            push_pop,
    output logic            pass_immediate,
    output logic [ALUW-1:0] alu_function,
    output logic            illegal_op
);

    ctrl_t ctrl_c;
    logic  legal_c;
    logic  illegal_d;
    logic  illegal_q;

    // Opcode decode; undefined encodings fall to the default arm as a NOP.
    always_comb begin
        ctrl_c  = '0;
        legal_c = 1'b1;
        case (opcode)
            NOP_OP:  ctrl_c.alu = ALU_NOP;
            SETC_OP: ctrl_c.alu = ALU_SETC;
            CLRC_OP: ctrl_c.alu = ALU_CLRC;
            NOT_OP, INC_OP, DEC_OP,
            MOV_OP, ADD_OP, SUB_OP, AND_OP, OR_OP, SHL_OP, SHR_OP: begin
                ctrl_c.data_read  = 1'b1;
                ctrl_c.data_write = 1'b1;
                case (opcode)
                    NOT_OP:  ctrl_c.alu = ALU_NOT;
                    INC_OP:  ctrl_c.alu = ALU_INC;
                    DEC_OP:  ctrl_c.alu = ALU_DEC;
                    MOV_OP:  ctrl_c.alu = ALU_PASS;
                    ADD_OP:  ctrl_c.alu = ALU_ADD;
                    SUB_OP:  ctrl_c.alu = ALU_SUB;
                    AND_OP:  ctrl_c.alu = ALU_AND;
                    OR_OP:   ctrl_c.alu = ALU_OR;
                    SHL_OP:  ctrl_c.alu = ALU_SHL;
                    default: ctrl_c.alu = ALU_SHR;
                endcase
            end
            OUT_OP: begin
                ctrl_c.data_read = 1'b1;
                ctrl_c.ioe       = 1'b1;
                ctrl_c.iow       = 1'b1;
                ctrl_c.alu       = ALU_PASSB;
            end
            IN_OP: begin
                ctrl_c.data_write = 1'b1;
                ctrl_c.ioe        = 1'b1;
                ctrl_c.ior        = 1'b1;
                ctrl_c.alu        = ALU_NOP;
            end
            PUSH_OP: begin
                ctrl_c.data_read = 1'b1;
                ctrl_c.dmw       = 1'b1;
                ctrl_c.stack_op  = 1'b1;
                ctrl_c.push_pop  = 1'b1;
                ctrl_c.alu       = ALU_PASSB;
            end
            POP_OP: begin
                ctrl_c.data_write = 1'b1;
                ctrl_c.dmr        = 1'b1;
                ctrl_c.stack_op   = 1'b1;
                ctrl_c.alu        = ALU_NOP;
            end
            LDM_OP: begin
                ctrl_c.data_write = 1'b1;
                ctrl_c.dmr        = 1'b1;
                ctrl_c.pass_imm   = 1'b1;
                ctrl_c.alu        = ALU_PASS;
            end
            LDD_OP: begin
                ctrl_c.data_read  = 1'b1;
                ctrl_c.data_write = 1'b1;
                ctrl_c.dmr        = 1'b1;
                ctrl_c.alu        = ALU_PASS;
            end
            STD_OP: begin
                ctrl_c.data_read = 1'b1;
                ctrl_c.dmw       = 1'b1;
                ctrl_c.alu       = ALU_PASS;
            end
            JZ_OP, JN_OP, JC_OP: begin
                ctrl_c.branch    = 1'b1;
                ctrl_c.data_read = 1'b1;
                ctrl_c.alu       = ALU_PASSB;
            end
            JMP_OP, CALL_OP: begin
                ctrl_c.branch = 1'b1;
                ctrl_c.alu    = ALU_PASSB;
            end
            RET_OP: begin
                ctrl_c.branch = 1'b1;
                ctrl_c.alu    = ALU_NOP;
            end
            default: begin
                ctrl_c  = '0;
                legal_c = 1'b0;
            end
        endcase
    end

    assign illegal_d = illegal_q | ~legal_c;

    // Sticky debug flag; only a reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign branch          = ctrl_c.branch;
    assign data_read       = ctrl_c.data_read;
    assign data_write      = ctrl_c.data_write;
    assign DMR             = ctrl_c.dmr;
    assign DMW             = ctrl_c.dmw;
    assign IOE             = ctrl_c.ioe;
    assign IOR             = ctrl_c.ior;
    assign IOW             = ctrl_c.iow;
    assign stack_operation = ctrl_c.stack_op;
    assign push_pop        = ctrl_c.push_pop;
    assign pass_immediate  = ctrl_c.pass_imm;
    assign alu_function    = ctrl_c.alu;
    assign illegal_op      = illegal_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus queues hand-computed expectations,
// a monitor pops and compares them on each sample strobe.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [8:0] opcode;
    logic       branch, data_read, data_write, DMR, DMW, IOE, IOR, IOW;
    logic       stack_operation, push_pop, pass_immediate, illegal_op;
    logic [3:0] alu_function;

    control_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .branch          (branch),
        .data_read       (data_read),
        .data_write      (data_write),
        .DMR             (DMR),
        .DMW             (DMW),
        .IOE             (IOE),
        .IOR             (IOR),
        .IOW             (IOW),
        .stack_operation (stack_operation),
        .push_pop        (push_pop),
        .pass_immediate  (pass_immediate),
        .alu_function    (alu_function),
        .illegal_op      (illegal_op)
    );

    always #5 clk = ~clk;

    // Strobe order: branch,data_read,data_write,DMR,DMW,IOE,IOR,IOW,stack,push_pop,imm
    typedef struct packed {
        logic [8:0]  op;
        logic [10:0] s;
        logic [3:0]  a;
        logic        def;
    } vec_t;

    typedef struct packed {
        logic [8:0]  op;
        logic [10:0] s;
        logic [3:0]  a;
        logic        ill;
    } exp_t;

    vec_t tbl [26] = '{
        '{9'h000, 11'b00000000000, 4'b0000, 1'b1},
        '{9'h001, 11'b00000000000, 4'b0001, 1'b1},
        '{9'h002, 11'b00000000000, 4'b0010, 1'b1},
        '{9'h020, 11'b01100000000, 4'b0101, 1'b1},
        '{9'h021, 11'b01100000000, 4'b0110, 1'b1},
        '{9'h022, 11'b01100000000, 4'b0111, 1'b1},
        '{9'h023, 11'b01000101000, 4'b0100, 1'b1},
        '{9'h024, 11'b00100110000, 4'b0000, 1'b1},
        '{9'h040, 11'b01100000000, 4'b0011, 1'b1},
        '{9'h041, 11'b01100000000, 4'b1000, 1'b1},
        '{9'h042, 11'b01100000000, 4'b1001, 1'b1},
        '{9'h043, 11'b01100000000, 4'b1010, 1'b1},
        '{9'h044, 11'b01100000000, 4'b1011, 1'b1},
        '{9'h045, 11'b01100000000, 4'b1100, 1'b1},
        '{9'h046, 11'b01100000000, 4'b1101, 1'b1},
        '{9'h060, 11'b01001000110, 4'b0100, 1'b1},
        '{9'h061, 11'b00110000100, 4'b0000, 1'b1},
        '{9'h062, 11'b00110000001, 4'b0011, 1'b1},
        '{9'h063, 11'b01110000000, 4'b0011, 1'b1},
        '{9'h064, 11'b01001000000, 4'b0011, 1'b1},
        '{9'h080, 11'b11000000000, 4'b0100, 1'b1},
        '{9'h081, 11'b11000000000, 4'b0100, 1'b1},
        '{9'h082, 11'b11000000000, 4'b0100, 1'b1},
        '{9'h084, 11'b10000000000, 4'b0100, 1'b1},
        '{9'h086, 11'b10000000000, 4'b0100, 1'b1},
        '{9'h088, 11'b10000000000, 4'b0000, 1'b1}
    };

    exp_t exp_q[$];
    logic exp_ill;
    logic chk_stb = 1'b0;
    int   checks = 0;
    int   passed = 0;

    // Queue an expectation for the current opcode and fire the sample strobe.
    task automatic expect_now(input logic [10:0] s, input logic [3:0] a);
        exp_t e;
        e.op  = opcode;
        e.s   = s;
        e.a   = a;
        e.ill = exp_ill;
        exp_q.push_back(e);
        #1 chk_stb = 1'b1;
        #1 chk_stb = 1'b0;
    endtask

    // One full clock period starting at a falling edge; the rising edge samples op.
    task automatic apply(input vec_t v);
        opcode = v.op;
        expect_now(v.s, v.a);
        #8;
        if (!v.def && rst_n) exp_ill = 1'b1;
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    initial begin
        exp_t e;
        logic [15:0] act;
        forever begin
            @(posedge chk_stb);
            act = {branch, data_read, data_write, DMR, DMW, IOE, IOR, IOW,
                   stack_operation, push_pop, pass_immediate, alu_function, illegal_op};
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty op=%h act=%b", opcode, act);
            end else begin
                e = exp_q.pop_front();
                if (act == {e.s, e.a, e.ill})
                    passed++;
                else
                    $display("FAIL op_%h strobes/alu/ill act=%b_%b_%b exp=%b_%b_%b",
                             e.op, act[15:5], act[4:1], act[0], e.s, e.a, e.ill);
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        rst_n   = 1'b0;
        opcode  = 9'h0FF;
        exp_ill = 1'b0;
        @(negedge clk);
        // Undefined opcode while held in reset: flag must stay clear.
        apply('{9'h0FF, 11'b0, 4'b0000, 1'b0});
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i]);

        // PUSH then POP: push_pop 1 then 0, DMW/DMR swap.
        apply(tbl[15]);
        apply(tbl[16]);
        apply(tbl[18]);
        apply(tbl[17]);

        // Undefined opcodes decode as NOP; flag sets at the next edge.
        apply('{9'h0FF, 11'b0, 4'b0000, 1'b0});
        apply('{9'h041, 11'b01100000000, 4'b1000, 1'b1});
        apply('{9'h100, 11'b0, 4'b0000, 1'b0});
        apply('{9'h003, 11'b0, 4'b0000, 1'b0});
        apply('{9'h083, 11'b0, 4'b0000, 1'b0});
        apply('{9'h1FF, 11'b0, 4'b0000, 1'b0});

        // Async reset pulse mid-cycle clears the sticky flag immediately.
        opcode = 9'h000;
        #1 rst_n = 1'b0;
        exp_ill  = 1'b0;
        expect_now(11'b0, 4'b0000);
        rst_n = 1'b1;
        #7;
        for (int i = 3; i < 26; i += 4) apply(tbl[i]);

        // Opcode changes between clock edges: outputs follow immediately.
        opcode = 9'h024;
        expect_now(11'b00100110000, 4'b0000);
        opcode = 9'h060;
        expect_now(11'b01001000110, 4'b0100);
        opcode = 9'h088;
        expect_now(11'b10000000000, 4'b0000);
        #4;

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) #1;
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
